// File: rtl/seven_seg_pkg.sv
// Shared types, constants and hex decode for the seven-segment scanner.
package seven_seg_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t BLANK = 2'd1;
  localparam state_t DRIVE = 2'd2;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low cathodes, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Value inputs and display pin outputs of the seven-segment scanner.
interface seven_seg_scanner_if;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;

  modport master (
    output enable, value, dp_in,
    input  an, seg, dp, digit_idx
  );

  modport slave (
    input  enable, value, dp_in,
    output an, seg, dp, digit_idx
  );
endinterface

// File: rtl/scan_tick_sync.sv
// Two-flop synchroniser plus edge flop; tick pulses one cycle per rising edge of async_in.
module scan_tick_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic tick
);
  logic s1, s2, s3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;
endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit common-anode driver with per-digit blanking.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits 3..1.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 100
) (
  input  logic               clk_100mHz_in,
  input  logic               reset,
  input  logic               scan_clk_in,
  seven_seg_scanner_if.slave bus
);
  localparam logic [11:0] RELOAD = 12'(BLANK_CYCLES - 1);

  logic        tick;
  logic        advance;
  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] val_q, val_d;
  logic [3:0]  dps_q, dps_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  nib;
  logic        lead_blank;

  scan_tick_sync u_sync (
    .clk      (clk_100mHz_in),
    .reset    (reset),
    .async_in (scan_clk_in),
    .tick     (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    val_d   = val_q;
    dps_d   = dps_q;
    advance = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_d = BLANK;
            idx_d   = 2'd0;
            cnt_d   = RELOAD;
            val_d   = bus.value;
            dps_d   = bus.dp_in;
          end
        end
        BLANK: begin
          if (tick)               advance = 1'b1;
          else if (cnt_q == '0)   state_d = DRIVE;
          else                    cnt_d   = cnt_q - 12'd1;
        end
        DRIVE:   advance = tick;
        default: state_d = IDLE;
      endcase
      if (advance) begin
        state_d = BLANK;
        idx_d   = idx_q + 2'd1;
        cnt_d   = RELOAD;
        // Snapshot only at the start of a frame so digits never mix two values.
        if (idx_q == 2'd3) begin
          val_d = bus.value;
          dps_d = bus.dp_in;
        end
      end
    end
  end

  always_comb begin
    case (idx_d)
      2'd0:    nib = val_d[3:0];
      2'd1:    nib = val_d[7:4];
      2'd2:    nib = val_d[11:8];
      default: nib = val_d[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    case (idx_d)
      2'd1:    lead_blank = (val_d[15:4] == 12'h0);
      2'd2:    lead_blank = (val_d[15:8] == 8'h0);
      2'd3:    lead_blank = (val_d[15:12] == 4'h0);
      default: lead_blank = 1'b0;
    endcase
  end
`else
  assign lead_blank = 1'b0;
`endif

  // Outputs are registered from next-state so they change on the same edge as the state.
  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == DRIVE) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = lead_blank ? SEG_OFF : hex_to_seg(nib);
      dp_d  = ~dps_d[idx_d];
    end
  end

  always_ff @(posedge clk_100mHz_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      val_q   <= '0;
      dps_q   <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      val_q   <= val_d;
      dps_q   <= dps_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign bus.an        = an_q;
  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.digit_idx = idx_q;
endmodule
